toggle_arbiter: RTL and testbench
=================================

// Module: toggle_arbiter
// PURPOSE
//  Shares one enable-gated toggle flip-flop cell (q <= q ^ d when en=1, else hold)
//  between NREQ requesters.
//  Round-robin arbiter and 3-state FSM. Each grant drives exactly one en/d
//  cycle into the cell and returns a one-cycle ack with the updated q.
//  Sits between client logic and the shared toggle state bit.
// PARAMETERS
//  NREQ  4  number of requesters (2..8); sets width of req/d_in/gnt/ack
// PORTS
//  clk     in   1     rising-edge clock; single clock domain
//  rst_n   in   1     reset: synchronous, active-low
//  req     in   NREQ  per-requester request; held high until matching ack
//  d_in    in   NREQ  per-requester toggle bit; stable while req high
//  gnt     out  NREQ  one-hot grant, registered; high only in ISSUE
//  ack     out  NREQ  one-hot completion pulse, registered; high only in RESP
//  q_out   out  1     current shared cell state (cell q, direct)
//  busy    out  1     1 when FSM not in IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE; gnt=0; ack=0; busy=0; cell q=0; ptr=NREQ-1, so req[0] wins first.
//   - Overrides everything, including mid-ISSUE/RESP: no ack issued, toggle discarded.
//  FSM states (2-bit): IDLE=0, ISSUE=1, RESP=2; code 3 -> IDLE.
//  IDLE:
//   - If any req: sel = first set bit searching ptr+1, ptr+2, ... (mod NREQ).
//   - Next cycle ISSUE with gnt=onehot(sel). Else stay.
//  ISSUE:
//   - Cell en=1, cell d=d_in[sel]; q toggles at end of cycle iff d_in[sel]=1.
//   - Always -> RESP.
//  RESP:
//   - ack[sel]=1; q_out already shows the new value.
//   - ptr<=sel.
//   - Arbitrate over req & ~onehot(sel), starting at sel+1; the acked requester is masked.
//   - Any hit -> ISSUE directly (back-to-back); none -> IDLE.
//  Cell en=0 in IDLE and RESP, so q holds.
//  Latency:
//   - req sampled in IDLE at cycle N: gnt at N+1, ack and new q_out at N+2.
//   - Sustained throughput: one op per 2 cycles.
//  Boundaries:
//   - Requester drops req before grant: not served; no ack.
//   - req dropped during ISSUE: op still completes and acks.
//   - All NREQ pending: strict rotation, no requester waits more than NREQ ops.
//   - ptr wraps NREQ-1 -> 0.
//   - d_in=0 op: completes normally, q unchanged.
//   - gnt and ack are never both nonzero in the same cycle.
//   - At most one bit set in each.
// STRUCTURE
//  toggle_arbiter_defs.vh holds shared constants:
//   - state encodings ST_IDLE/ST_ISSUE/ST_RESP and default NREQ.
//  Sub-module toggle_cell (clk, rst_n, en, d, q):
//   - Sync active-low reset to 0, then q <= en ? q^d : q.
//   - Instantiated once.
//  Round-robin pick is a function in this module: rotate, priority-encode, unrotate.
// TESTING
//  1 rst_n=0 for 3 cycles -> gnt=0, ack=0, busy=0, q_out=0; first grant after release goes to req[0].
//  2 req=0001, d_in=0001 -> gnt=0001 at N+1, ack=0001 at N+2, q_out=1; repeat -> q_out=0.
//  3 req=1111, d_in=1111 held, each req dropped after ack:
//    - grant order 0,1,2,3 at 2-cycle spacing.
//    - q_out 1,0,1,0.
//  4 req=0100, d_in=0000 -> ack=0100 after 2 cycles, q_out stays 0.
//  5 q_out=0, grant to req[2] (d=1), rst_n=0 during ISSUE -> no ack[2], q_out=0, busy=0.
//  6 req=1001 with ptr=0 -> req[3] granted before req[0]; req[1] pulsed 1 cycle while busy -> never acked.

Source files
------------

// File: rtl/toggle_arbiter_pkg.sv
// Shared types and constants for the toggle arbiter slice.
package toggle_arbiter_pkg;

  localparam int DEFAULT_NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arbState_e;

endpackage

// File: rtl/toggle_arbiter_if.sv
// Request/grant bundle between client logic and the shared toggle arbiter.
interface toggle_arbiter_if
  import toggle_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ
) ();

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] d_in;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic            q_out;
  logic            busy;

  modport master (output req, d_in, input gnt, ack, q_out, busy);
  modport slave  (input req, d_in, output gnt, ack, q_out, busy);

endinterface

// File: rtl/toggle_arbiter_cell.sv
// Enable-gated toggle flip-flop shared by all requesters of the arbiter.
module toggle_arbiter_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  assign q_d = en_i ? (q_q ^ d_i) : q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/toggle_arbiter.sv
// Round-robin arbiter granting one toggle operation at a time on a shared cell,
// acknowledging each with the updated cell state.
module toggle_arbiter
  import toggle_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ
) (
  input logic clk,
  input logic rst_n,
  toggle_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arbState_e       state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   sel_q;

  logic [NREQ-1:0] selOneHot;
  logic [NREQ-1:0] pickReq;
  logic [PW-1:0]   pickFrom;
  logic [PW:0]     pick;
  logic [NREQ-1:0] pickOneHot;
  logic            cellEn;
  logic            cellD;
  logic            cellQ;

  // Rotate so the slot after 'last' sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [PW:0] rrPick(input logic [NREQ-1:0] reqs,
                                         input logic [PW-1:0]   last);
    logic [NREQ-1:0] rot;
    int              startIdx;
    int              k;
    startIdx = (int'(last) + 1) % NREQ;
    rot      = NREQ'({reqs, reqs} >> startIdx);
    k        = -1;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) k = i;
    end
    if (k < 0) return '0;
    return {1'b1, PW'((startIdx + k) % NREQ)};
  endfunction

  // In RESP the requester just served is masked and the search starts after it.
  always_comb begin
    selOneHot        = '0;
    selOneHot[sel_q] = 1'b1;
    pickReq          = bus.req;
    pickFrom         = ptr_q;
    if (state_q == ST_RESP) begin
      pickReq  = bus.req & ~selOneHot;
      pickFrom = sel_q;
    end
    pick                       = rrPick(pickReq, pickFrom);
    pickOneHot                 = '0;
    pickOneHot[pick[PW-1:0]]   = pick[PW];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
      sel_q   <= '0;
    end else begin
      gnt_q <= '0;
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick[PW]) begin
            state_q <= ST_ISSUE;
            sel_q   <= pick[PW-1:0];
            gnt_q   <= pickOneHot;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_RESP;
          ack_q   <= selOneHot;
        end
        ST_RESP: begin
          ptr_q <= sel_q;
          if (pick[PW]) begin
            state_q <= ST_ISSUE;
            sel_q   <= pick[PW-1:0];
            gnt_q   <= pickOneHot;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cellEn = (state_q == ST_ISSUE);
  assign cellD  = bus.d_in[sel_q];

  toggle_arbiter_cell u_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (cellEn),
    .d_i   (cellD),
    .q_o   (cellQ)
  );

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.q_out = cellQ;
  assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_toggle_arbiter.sv
// Directed and randomized check of toggle_arbiter against a transaction-level
// model: round-robin choice over pending requests, grant then ack, cell toggled by d.
module tb_toggle_arbiter;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  toggle_arbiter_if #(.NREQ(N)) bus ();

  toggle_arbiter #(.NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int           vectors     = 0;
  int           miscompares = 0;
  int           expGnt      = -1;
  int           expAck      = -1;
  int           lastServed  = N - 1;
  logic         expQ        = 1'b0;
  bit           modelValid  = 1'b0;
  logic [N-1:0] curReq      = '0;
  logic [N-1:0] curD        = '0;

  function automatic logic [N-1:0] oneHot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // First pending requester after the last one served, wrapping around.
  function automatic int rrPick(input logic [N-1:0] cand, input int last);
    for (int i = 1; i <= N; i++) begin
      if (cand[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic checkOutput();
    if (modelValid) begin
      checkVal("gnt",   8'(bus.gnt),   8'(oneHot(expGnt)));
      checkVal("ack",   8'(bus.ack),   8'(oneHot(expAck)));
      checkVal("q_out", 8'(bus.q_out), 8'(expQ));
      checkVal("busy",  8'(bus.busy),  8'((expGnt >= 0) || (expAck >= 0)));
    end
  endtask

  // One clock: check the interval just entered, then drive the next inputs and
  // advance the model. Requesters acked in this interval release their request.
  task automatic applyStimulus(input logic rstIn, input logic [N-1:0] r, input logic [N-1:0] d);
    int nextGnt;
    int nextAck;
    @(posedge clk);
    #1;
    checkOutput();
    curReq     = r & ~oneHot(expAck);
    curD       = d;
    rst_n      = rstIn;
    bus.req    = curReq;
    bus.d_in   = curD;
    if (!rstIn) begin
      expGnt     = -1;
      expAck     = -1;
      expQ       = 1'b0;
      lastServed = N - 1;
    end else begin
      nextAck = expGnt;
      nextGnt = -1;
      if (expGnt >= 0) begin
        expQ = expQ ^ d[expGnt];
      end else begin
        if (expAck >= 0) lastServed = expAck;
        nextGnt = rrPick(curReq & ~oneHot(expAck), lastServed);
      end
      expGnt = nextGnt;
      expAck = nextAck;
    end
    modelValid = 1'b1;
  endtask

  task automatic holdCycles(input int n);
    repeat (n) applyStimulus(1'b1, curReq, curD);
  endtask

  task automatic resetCycles(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0);
  endtask

  initial begin
    bus.req  = '0;
    bus.d_in = '0;

    $display("[TB] reset and single-requester toggles");
    resetCycles(3);
    applyStimulus(1'b1, 4'b0001, 4'b0001);
    holdCycles(3);
    applyStimulus(1'b1, 4'b0001, 4'b0001);
    holdCycles(3);

    $display("[TB] all requesters pending, strict rotation");
    resetCycles(2);
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    holdCycles(10);

    $display("[TB] d_in=0 operation leaves q unchanged");
    applyStimulus(1'b1, 4'b0100, 4'b0000);
    holdCycles(3);

    $display("[TB] reset during ISSUE discards the toggle");
    applyStimulus(1'b1, 4'b0100, 4'b0100);
    applyStimulus(1'b0, 4'b0100, 4'b0100);
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    holdCycles(2);

    $display("[TB] pointer after req[0], short pulse on req[1]");
    applyStimulus(1'b1, 4'b0001, 4'b0000);
    holdCycles(3);
    applyStimulus(1'b1, 4'b1001, 4'b1001);
    applyStimulus(1'b1, 4'b1011, 4'b1011);
    applyStimulus(1'b1, 4'b1001, 4'b1001);
    holdCycles(6);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] r;
      logic [N-1:0] d;
      r = curReq;
      d = curD;
      for (int i = 0; i < N; i++) begin
        if (!curReq[i] && ($urandom_range(2) == 0)) begin
          r[i] = 1'b1;
          d[i] = 1'($urandom_range(1));
        end else if (curReq[i] && ($urandom_range(15) == 0)) begin
          r[i] = 1'b0;
        end
      end
      applyStimulus(1'($urandom_range(63) != 0), r, d);
    end
    holdCycles(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
